hs_reg_slice: RTL

- Parametrised valid/ready register slice for inserting timing breaks on 8-bit-class streaming links between pipeline stages.
- It generalises the single-entry forward slice.
- MODE selects which combinational paths are broken: none, valid/data, ready, or both.
- In every mode it is lossless, keeps data in order, and adds no bubbles under continuous flow.

---
 rtl/hs_reg_slice_if.sv | 32 +++
 rtl/hs_reg_slice.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/hs_reg_slice_if.sv
// ============================================================================
// Module  : hs_reg_slice_if
// Purpose : Valid/ready stream bundle (upstream side, downstream side, fill level)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface hs_reg_slice_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] up_data;
  logic              up_valid;
  logic              up_ready;
  logic [DATA_W-1:0] down_data;
  logic              down_valid;
  logic              down_ready;
  logic [1:0]        occupancy;

  // Environment side: sources the upstream stream and sinks the downstream one.
  modport master (
    output up_data, up_valid, down_ready,
    input  up_ready, down_data, down_valid, occupancy
  );

  // Slice side.
  modport slave (
    input  up_data, up_valid, down_ready,
    output up_ready, down_data, down_valid, occupancy
  );
endinterface

`default_nettype wire

// File: rtl/hs_reg_slice.sv
// ============================================================================
// Module  : hs_reg_slice
// Purpose : Valid/ready register slice; MODE picks which paths are registered
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hs_reg_slice #(
  parameter int DATA_W = 8,
  parameter int MODE   = 3
) (
  input  logic          clk,
  input  logic          rst,
  hs_reg_slice_if.slave slv
);

  generate
    if (MODE < 0 || MODE > 3 || DATA_W < 1) begin : g_bad_mode
      $error("hs_reg_slice: MODE must be 0..3 and DATA_W >= 1");
    end else if (MODE == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst  = clk ^ rst;
      assign slv.down_data   = slv.up_data;
      assign slv.down_valid  = slv.up_valid;
      assign slv.up_ready    = slv.down_ready;
      assign slv.occupancy   = 2'd0;
    end else if (MODE == 1) begin : g_fwd
      logic              full_q, full_d;
      logic [DATA_W-1:0] data_q, data_d;
      logic              rdy;
      logic              push, pop;

      assign rdy  = slv.down_ready | ~full_q;
      assign push = slv.up_valid & rdy;
      assign pop  = full_q & slv.down_ready;

      // Push wins over pop: a simultaneous pair replaces the word in place.
      always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (push) begin
          full_d = 1'b1;
          data_d = slv.up_data;
        end else if (pop) begin
          full_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          full_q <= 1'b0;
          data_q <= '0;
        end else begin
          full_q <= full_d;
          data_q <= data_d;
        end
      end

      assign slv.up_ready   = rdy;
      assign slv.down_valid = full_q;
      assign slv.down_data  = data_q;
      assign slv.occupancy  = {1'b0, full_q};
    end else if (MODE == 2) begin : g_skid
      logic              skid_full_q, skid_full_d;
      logic [DATA_W-1:0] skid_data_q, skid_data_d;

      // up_ready is ~skid_full_q, so an up handshake implies the skid is empty.
      always_comb begin
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        if (skid_full_q) begin
          if (slv.down_ready) skid_full_d = 1'b0;
        end else if (slv.up_valid && !slv.down_ready) begin
          skid_full_d = 1'b1;
          skid_data_d = slv.up_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          skid_full_q <= 1'b0;
          skid_data_q <= '0;
        end else begin
          skid_full_q <= skid_full_d;
          skid_data_q <= skid_data_d;
        end
      end

      assign slv.up_ready   = ~skid_full_q;
      assign slv.down_valid = slv.up_valid | skid_full_q;
      assign slv.down_data  = skid_full_q ? skid_data_q : slv.up_data;
      assign slv.occupancy  = {1'b0, skid_full_q};
    end else begin : g_full
      logic [DATA_W-1:0] mem_q [2];
      logic              head_q, head_d;
      logic              tail_q, tail_d;
      logic [1:0]        count_q, count_d;
      logic              rdy, vld;
      logic              push, pop;

      assign rdy  = (count_q != 2'd2);
      assign vld  = (count_q != 2'd0);
      assign push = slv.up_valid & rdy;
      assign pop  = vld & slv.down_ready;

      always_comb begin
        head_d  = head_q ^ pop;
        tail_d  = tail_q ^ push;
        count_d = count_q;
        case ({push, pop})
          2'b10:   count_d = count_q + 2'd1;
          2'b01:   count_d = count_q - 2'd1;
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          head_q   <= 1'b0;
          tail_q   <= 1'b0;
          count_q  <= 2'd0;
          mem_q[0] <= '0;
          mem_q[1] <= '0;
        end else begin
          head_q  <= head_d;
          tail_q  <= tail_d;
          count_q <= count_d;
          if (push) mem_q[tail_q] <= slv.up_data;
        end
      end

      assign slv.up_ready   = rdy;
      assign slv.down_valid = vld;
      assign slv.down_data  = mem_q[head_q];
      assign slv.occupancy  = count_q;
    end
  endgenerate

endmodule

`default_nettype wire
